// File: rtl/npu_pkg.sv
// Shared constants, pixel type and serializer state encoding for the flatten stage.
// Optional build macro used by the serializer: FLATTEN_SERIALIZER_ROW_LAST_EN.
package npu_pkg;

  localparam int DATA_WIDTH = 22;
  localparam int NUM_PIXELS = 225;
  localparam int ROW_LEN    = 15;
  localparam int ADDR_WIDTH = 8;
  localparam int COL_WIDTH  = $clog2(ROW_LEN);

  typedef logic signed [DATA_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } ser_state_e;

endpackage

// File: rtl/flatten_index_counter.sv
// Mod-MODULUS counter with synchronous clear, enable and terminal-count flag.
module flatten_index_counter #(
  parameter int MODULUS = 225,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign terminal = (count == LAST);

  // NOTE: sequential state uses <= so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/flatten_serializer.sv
// Parallel-to-serial readback of the flattened 15x15 map over a valid/ready stream.
// Build macro FLATTEN_SERIALIZER_ROW_LAST_EN adds the row_last output and column counter.
module flatten_serializer
  import npu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_signal,
  input  pixel_t                data_in [0:NUM_PIXELS-1],
  input  logic                  pixel_ready,
  output logic                  pixel_valid,
  output pixel_t                pixel_out,
  output logic [ADDR_WIDTH-1:0] pixel_index,
  output logic                  pixel_last,
  output logic                  busy,
  output logic                  done_signal
`ifdef FLATTEN_SERIALIZER_ROW_LAST_EN
  ,
  output logic                  row_last
`endif
);

  ser_state_e            state_q;
  ser_state_e            state_d;
  pixel_t                buffer [0:NUM_PIXELS-1];
  logic                  start_accept;
  logic                  transfer;
  logic                  advance;
  logic                  idx_terminal;
  logic [ADDR_WIDTH-1:0] next_index;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    start_accept = 1'b0;
    transfer     = 1'b0;
    pixel_valid  = 1'b0;
    busy         = 1'b0;
    done_signal  = 1'b0;
    case (state_q)
      IDLE: begin
        start_accept = start_signal;
        if (start_signal) state_d = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        busy        = 1'b1;
        pixel_valid = 1'b1;
        transfer    = pixel_ready;
        if (pixel_ready && idx_terminal) state_d = DONE;
      end
      DONE: begin
        done_signal  = 1'b1;
        start_accept = start_signal;
        state_d      = start_signal ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The index never wraps inside a stream: the last transfer leaves it parked at the end.
  assign advance    = transfer && !idx_terminal;
  assign next_index = pixel_index + ADDR_WIDTH'(1);
  assign pixel_last = pixel_valid && idx_terminal;

  flatten_index_counter #(
    .MODULUS (NUM_PIXELS),
    .WIDTH   (ADDR_WIDTH)
  ) u_index_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_accept),
    .enable   (advance),
    .count    (pixel_index),
    .terminal (idx_terminal)
  );

  // NOTE: the capture buffer is cleared on reset so an aborted stream leaves no stale pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PIXELS; i++) buffer[i] <= '0;
    end else if (start_accept) begin
      buffer <= data_in;
    end
  end

  // pixel_out is registered so it holds across stalls and after the stream ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_out <= '0;
    end else if (state_q == LOAD) begin
      pixel_out <= buffer[0];
    end else if (advance) begin
      pixel_out <= buffer[next_index];
    end
  end

`ifdef FLATTEN_SERIALIZER_ROW_LAST_EN
  logic [COL_WIDTH-1:0] col_count;
  logic                 col_terminal;

  flatten_index_counter #(
    .MODULUS (ROW_LEN),
    .WIDTH   (COL_WIDTH)
  ) u_col_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_accept),
    .enable   (advance),
    .count    (col_count),
    .terminal (col_terminal)
  );

  assign row_last = pixel_valid && col_terminal && (col_count == COL_WIDTH'(ROW_LEN - 1));
`endif

endmodule

// File: tb/tb_flatten_serializer.sv
// Directed bench for flatten_serializer: full streams, stalls, ignored start, abort, back-to-back start.
module tb_flatten_serializer;
  import npu_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  start_signal;
  pixel_t                data_in [0:NUM_PIXELS-1];
  logic                  pixel_ready;
  logic                  pixel_valid;
  pixel_t                pixel_out;
  logic [ADDR_WIDTH-1:0] pixel_index;
  logic                  pixel_last;
  logic                  busy;
  logic                  done_signal;
`ifdef FLATTEN_SERIALIZER_ROW_LAST_EN
  logic                  row_last;
`endif

  int tests = 0;
  int fails = 0;

  flatten_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .start_signal (start_signal),
    .data_in      (data_in),
    .pixel_ready  (pixel_ready),
    .pixel_valid  (pixel_valid),
    .pixel_out    (pixel_out),
    .pixel_index  (pixel_index),
    .pixel_last   (pixel_last),
    .busy         (busy),
    .done_signal  (done_signal)
`ifdef FLATTEN_SERIALIZER_ROW_LAST_EN
    ,
    .row_last     (row_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NUM_PIXELS; i++) data_in[i] = pixel_t'(i - 112);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
  // kind 0: expect i-112, kind 1: expect 0x1FFFFF everywhere.
  task automatic run_stream(input int mode, input int kind, input int poke_at,
                            input int rst_at, output bit aborted);
    int  exp_i;
    int  cyc;
    int  rl_count;
    bit  poked;
    bit  r;
    logic signed [31:0] exp_val;
    exp_i    = 0;
    cyc      = 0;
    rl_count = 0;
    poked    = 1'b0;
    aborted  = 1'b0;
    pixel_ready  = 1'b1;
    start_signal = 1'b1;
    step();
    start_signal = 1'b0;
    check("load_busy", busy, 1);
    check("load_valid", pixel_valid, 0);
    check("load_done", done_signal, 0);
    step();
    while (exp_i < NUM_PIXELS && cyc < 4000) begin
      exp_val = (kind == 0) ? 32'(exp_i - 112) : 32'sd2097151;
      check("valid", pixel_valid, 1);
      check("busy", busy, 1);
      check("out", pixel_out, exp_val);
      check("index", pixel_index, exp_i);
      check("last", pixel_last, (exp_i == NUM_PIXELS - 1) ? 1 : 0);
`ifdef FLATTEN_SERIALIZER_ROW_LAST_EN
      check("row_last", row_last, (exp_i % ROW_LEN == ROW_LEN - 1) ? 1 : 0);
`endif
      if (exp_i == rst_at) begin
        rst     = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (exp_i == poke_at && !poked) begin
        start_signal = 1'b1;
        for (int i = 0; i < NUM_PIXELS; i++) data_in[i] = pixel_t'(1000 + i);
        poked = 1'b1;
      end else begin
        start_signal = 1'b0;
      end
      case (mode)
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      pixel_ready = r;
`ifdef FLATTEN_SERIALIZER_ROW_LAST_EN
      if (r && row_last) rl_count++;
`endif
      if (r) exp_i++;
      step();
      cyc++;
    end
    start_signal = 1'b0;
    check("transfers", exp_i, NUM_PIXELS);
`ifdef FLATTEN_SERIALIZER_ROW_LAST_EN
    check("row_pulses", rl_count, ROW_LEN);
`endif
  endtask

  task automatic check_done();
    check("done_pulse", done_signal, 1);
    check("done_busy", busy, 0);
    check("done_valid", pixel_valid, 0);
    check("done_last", pixel_last, 0);
  endtask

  initial begin
    bit aborted;
    rst          = 1'b0;
    start_signal = 1'b0;
    pixel_ready  = 1'b0;
    for (int i = 0; i < NUM_PIXELS; i++) data_in[i] = '0;
    step();
    step();
    check("rst_valid", pixel_valid, 0);
    check("rst_out", pixel_out, 0);
    check("rst_index", pixel_index, 0);
    check("rst_last", pixel_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_signal, 0);
    rst = 1'b1;
    step();

    // Full stream with ready held high.
    fill_ramp();
    run_stream(0, 0, -1, -1, aborted);
    check_done();
    step();
    check("idle_done", done_signal, 0);
    check("idle_busy", busy, 0);

    // Same data under a 1,0,0,1 ready pattern.
    run_stream(1, 0, -1, -1, aborted);
    check_done();
    step();
    check("idle_done2", done_signal, 0);

    // A start pulse with new data at index 50 must be ignored.
    run_stream(0, 0, 50, -1, aborted);
    check_done();
    step();
    check("idle_done3", done_signal, 0);
    fill_ramp();

    // Reset at index 100 aborts the stream without a done pulse.
    run_stream(0, 0, -1, 100, aborted);
    check("aborted", aborted, 1);
    step();
    check("abort_valid", pixel_valid, 0);
    check("abort_out", pixel_out, 0);
    check("abort_index", pixel_index, 0);
    check("abort_last", pixel_last, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done_signal, 0);
    rst = 1'b1;
    step();
    check("post_abort_done", done_signal, 0);
    check("post_abort_valid", pixel_valid, 0);

    // Restream from index 0, then start again inside the done cycle with max-positive data.
    run_stream(0, 0, -1, -1, aborted);
    check_done();
    for (int i = 0; i < NUM_PIXELS; i++) data_in[i] = pixel_t'(22'h1FFFFF);
    run_stream(0, 1, -1, -1, aborted);
    check_done();
    step();
    check("idle_done5", done_signal, 0);

`ifdef FLATTEN_SERIALIZER_ROW_LAST_EN
    // Row markers under random stalls.
    fill_ramp();
    run_stream(2, 0, -1, -1, aborted);
    check_done();
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
